// File: rtl/if_id_skid.sv
// ----------------------------------------------------------------------------
// if_id_skid
//   Two-entry in-order skid buffer between the instruction-fetch (IF) and
//   instruction-decode (ID) stages. The main register is the head entry and
//   drives the outputs. The skid register holds one younger entry, so that
//   o_ready can be a pure function of registered state.
//
// Handshake (both sides): an entry moves across an interface on a rising
//   edge where valid=1 and ready=1 in the cycle before that edge. Valid is
//   never withdrawn while ready is low. Payload is stable while valid=1 and
//   ready=0. o_ready does not depend combinationally on i_ready.
//
// Ports
//   clk          single clock, rising edge
//   rst          asynchronous active-low reset
//   i_flush      discard all held entries and the current input
//   i_valid      upstream entry valid
//   o_ready      this block accepts an upstream entry this cycle
//   i_pc/i_inst  upstream payload
//   o_valid      head entry valid toward ID
//   i_ready      downstream accepts the head entry this cycle
//   o_pc/o_inst  head payload (0 / NOP_INST when o_valid=0)
//   o_stall_cnt  saturating count of cycles with o_valid=1 and i_ready=0
//   o_state      current buffer state (0 EMPTY, 1 BUSY, 2 FULL), debug
// ----------------------------------------------------------------------------
module if_id_skid #(
   parameter int                PC_W     = 32,
   parameter int                INST_W   = 32,
   parameter logic [INST_W-1:0] NOP_INST = 32'h00000013,
   parameter int                CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_flush,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [PC_W-1:0]   i_pc,
   input  logic [INST_W-1:0] i_inst,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [PC_W-1:0]   o_pc,
   output logic [INST_W-1:0] o_inst,
   output logic [CNT_W-1:0]  o_stall_cnt,
   output logic [1:0]        o_state
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t state, next_state;

   logic [PC_W-1:0]   main_pc, skid_pc;
   logic [INST_W-1:0] main_inst, skid_inst;
   logic [CNT_W-1:0]  stall_cnt;

   logic enq, deq;
   logic load_main_in;    // main <= upstream input
   logic load_main_skid;  // main <= skid (skid drains forward)
   logic load_skid_in;    // skid <= upstream input

   // Handshake outputs come from the state register only.
   assign o_ready = (state != FULL);
   assign o_valid = (state != EMPTY);
   assign enq     = i_valid & o_ready;
   assign deq     = o_valid & i_ready;

   assign o_pc        = o_valid ? main_pc   : '0;
   assign o_inst      = o_valid ? main_inst : NOP_INST;
   assign o_stall_cnt = stall_cnt;
   assign o_state     = state;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= EMPTY;
      else      state <= next_state;
   end

   always_comb begin
      next_state     = state;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid_in   = 1'b0;
      if (i_flush) begin
         // Redirect: everything held and the current input are dropped.
         next_state = EMPTY;
      end else begin
         unique case (state)
            EMPTY: begin
               if (enq) begin
                  load_main_in = 1'b1;
                  next_state   = BUSY;
               end
            end
            BUSY: begin
               if (enq && deq) begin
                  load_main_in = 1'b1;
               end else if (enq) begin
                  load_skid_in = 1'b1;
                  next_state   = FULL;
               end else if (deq) begin
                  next_state   = EMPTY;
               end
            end
            FULL: begin
               // o_ready is 0 here, so i_valid cannot enqueue.
               if (deq) begin
                  load_main_skid = 1'b1;
                  next_state     = BUSY;
               end
            end
            default: next_state = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         main_pc   <= '0;
         main_inst <= '0;
         skid_pc   <= '0;
         skid_inst <= '0;
      end else begin
         if (load_main_in) begin
            main_pc   <= i_pc;
            main_inst <= i_inst;
         end else if (load_main_skid) begin
            main_pc   <= skid_pc;
            main_inst <= skid_inst;
         end
         if (load_skid_in) begin
            skid_pc   <= i_pc;
            skid_inst <= i_inst;
         end
      end
   end

   // Saturating stall counter; a flush cycle is not counted and does not clear it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
      end else if (!i_flush && o_valid && !i_ready && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: doc/if_id_skid.md
IF_ID_SKID -- requirements
Module: if_id_skid

Interface
REQ-001 Parameter PC_W, default 32, width of the program-counter fields.
REQ-002 Parameter INST_W, default 32, width of the instruction fields.
REQ-003 Parameter NOP_INST, default 32'h00000013, instruction presented whenever no valid entry is output.
REQ-004 Parameter CNT_W, default 16, width of the stall counter.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset; asserting it (0) resets immediately, deassertion is synchronous to clk.
REQ-007 i_flush  in  1  discard all held entries (branch/exception redirect).
REQ-008 i_valid  in  1  upstream (IF) entry valid.
REQ-009 o_ready  out  1  this block accepts an upstream entry this cycle.
REQ-010 i_pc  in  PC_W  upstream PC.
REQ-011 i_inst  in  INST_W  upstream instruction.
REQ-012 o_valid  out  1  downstream (ID) entry valid.
REQ-013 i_ready  in  1  downstream accepts the entry this cycle.
REQ-014 o_pc  out  PC_W  PC of head entry.
REQ-015 o_inst  out  INST_W  instruction of head entry.
REQ-016 o_stall_cnt  out  CNT_W  count of cycles with o_valid=1 and i_ready=0.

Function
REQ-017 Two-entry in-order buffer: main register (head, drives outputs) and skid register (younger entry).
REQ-018 States: EMPTY (0 entries), BUSY (main only), FULL (main+skid).
REQ-019 enq = i_valid & o_ready; deq = o_valid & i_ready.
REQ-020 o_ready = 1 in EMPTY and BUSY, 0 in FULL; driven from registered state only, with no combinational path from i_ready.
REQ-021 o_valid = 1 in BUSY and FULL, 0 in EMPTY.
REQ-022 EMPTY: enq -> load main, go BUSY; otherwise stay.
REQ-023 BUSY: enq&deq -> load main with input, stay BUSY; enq only -> load skid, go FULL; deq only -> go EMPTY; neither -> hold.
REQ-024 FULL: deq -> move skid to main, go BUSY; no deq -> hold both; i_valid ignored.
REQ-025 Latency: an entry accepted in cycle N appears on o_pc/o_inst with o_valid=1 in cycle N+1 when the block was EMPTY, or when it was BUSY with a simultaneous deq.
REQ-026 Entries leave in acceptance order; none is duplicated or dropped except by flush.
REQ-027 When o_valid=0, o_inst = NOP_INST and o_pc = 0.
REQ-028 i_flush=1 -> next state EMPTY regardless of enq/deq; the input in that cycle is discarded; o_ready=1 the following cycle.
REQ-029 Flush takes priority over simultaneous enq, deq and stall counting in the same cycle.
REQ-030 o_stall_cnt increments by 1 each cycle with o_valid=1, i_ready=0 and i_flush=0; it saturates at 2^CNT_W-1 and never wraps.
REQ-031 Flush does not clear o_stall_cnt.

Reset
REQ-032 On rst=0: state EMPTY, main and skid PC/instruction registers cleared to 0, o_stall_cnt=0.
REQ-033 During and immediately after reset: o_valid=0, o_ready=1, o_pc=0, o_inst=NOP_INST.
REQ-034 Reset asserted mid-operation (BUSY or FULL) discards all entries asynchronously, without waiting for a clock edge.

Verification
REQ-035 Stream: i_ready=1, enqueue PC 0x100/0x104/0x108 back-to-back -> outputs 0x100, 0x104, 0x108 on consecutive cycles, each one cycle after its acceptance; o_ready stays 1.
REQ-036 Backpressure: i_ready=0, enqueue 0x200 then 0x204 -> o_ready=0 after the second enqueue; 0x208 is held off; raise i_ready -> 0x200, 0x204, 0x208 out in order; o_stall_cnt equals the number of stalled cycles.
REQ-037 Flush in FULL with i_valid=1 (PC 0x300) -> next cycle o_valid=0, o_inst=0x00000013, o_ready=1; 0x300 never appears on the output.
REQ-038 Async reset: drop rst between clock edges while FULL -> o_valid=0 and o_stall_cnt=0 immediately; after release the first enqueue (0x400) appears one cycle later.
REQ-039 Saturation: CNT_W=4, hold o_valid=1 and i_ready=0 for 20 cycles -> o_stall_cnt stops at 15.
